// File: rtl/reg_status_table_pkg.sv
// Shared core constants and the register status entry type.
// Used by the tag FIFO, dispatch and the register status table.
package reg_status_table_pkg;

  localparam int NREG   = 32;
  localparam int AREG_W = 5;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic             pending;
    logic [TAG_W-1:0] tag;
  } rst_entry_t;

endpackage

// File: rtl/rst_lookup.sv
// Combinational source lookup with same-cycle CDB bypass.
// Ports: entries (table), addr, cdb_valid/cdb_tag in; pending, tag out.
module rst_lookup
  import reg_status_table_pkg::*;
(
  input  rst_entry_t [NREG-1:0] entries,
  input  logic [AREG_W-1:0]     addr,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  output logic                  pending,
  output logic [TAG_W-1:0]      tag
);

  rst_entry_t e;
  logic       hit;

  assign e   = entries[addr];
  // A broadcast of the awaited tag this cycle means the value is ready now.
  assign hit = cdb_valid && (cdb_tag == e.tag);

  assign pending = (addr != '0) && e.pending && !hit;
  assign tag     = pending ? e.tag : '0;

endmodule

// File: rtl/reg_status_table.sv
// Register status table: tracks which registers await an in-flight tag.
// Ports: clock, reset, flush, dispatch write, rs/rt lookups, CDB, count.
module reg_status_table
  import reg_status_table_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_wr_en,
  input  logic [AREG_W-1:0] disp_rd,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic [AREG_W-1:0] rs_addr,
  input  logic [AREG_W-1:0] rt_addr,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic [TAG_W-1:0]  rs_tag,
  output logic [TAG_W-1:0]  rt_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  output logic [AREG_W:0]   pending_count
);

  localparam logic [AREG_W:0] ONE = (AREG_W+1)'(1);

  rst_entry_t [NREG-1:0] entries;
  rst_entry_t [NREG-1:0] entries_nxt;
  logic [AREG_W:0]       count_nxt;
  logic [AREG_W:0]       hits;
  logic                  wr;
  logic                  inc;
  logic                  clr;

  always_comb begin
    entries_nxt = entries;
    hits        = '0;
    clr         = 1'b0;
    wr          = disp_wr_en && (disp_rd != '0);
    inc         = wr && !entries[disp_rd].pending;
    for (int i = 1; i < NREG; i++) begin
      if (cdb_valid && entries[i].pending &&
          entries[i].tag == cdb_tag) begin
        hits = hits + ONE;
        // A same-cycle rename of this register keeps the new tag.
        if (!(wr && disp_rd == AREG_W'(i))) begin
          entries_nxt[i].pending = 1'b0;
          clr = 1'b1;
        end
      end
    end
    if (wr) begin
      entries_nxt[disp_rd].pending = 1'b1;
      entries_nxt[disp_rd].tag     = disp_tag;
    end
    count_nxt = pending_count
              + (inc ? ONE : '0)
              - (clr ? ONE : '0);
    if (flush) begin
      entries_nxt = entries;
      for (int i = 0; i < NREG; i++) begin
        entries_nxt[i].pending = 1'b0;
      end
      count_nxt = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries       <= '0;
      pending_count <= '0;
    end else begin
      entries       <= entries_nxt;
      pending_count <= count_nxt;
    end
  end

  // Tags are unique in flight; a multi-entry match is a protocol error.
  always @(posedge clock) begin
    if (!reset && !flush) begin
      assert (hits <= ONE);
    end
  end

  rst_lookup u_rs (
    .entries   (entries),
    .addr      (rs_addr),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .pending   (rs_pending),
    .tag       (rs_tag)
  );

  rst_lookup u_rt (
    .entries   (entries),
    .addr      (rt_addr),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .pending   (rt_pending),
    .tag       (rt_tag)
  );

endmodule

// File: tb/tb_reg_status_table.sv
// Scoreboard bench for reg_status_table: directed cases then random traffic.
// Expected lookups/count come from an array model of the register state.
module tb_reg_status_table;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       disp_wr_en;
  logic [4:0] disp_rd;
  logic [4:0] disp_tag;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic       rs_pending;
  logic       rt_pending;
  logic [4:0] rs_tag;
  logic [4:0] rt_tag;
  logic       cdb_valid;
  logic [4:0] cdb_tag;
  logic [5:0] pending_count;

  reg_status_table dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .disp_wr_en    (disp_wr_en),
    .disp_rd       (disp_rd),
    .disp_tag      (disp_tag),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_pending    (rs_pending),
    .rt_pending    (rt_pending),
    .rs_tag        (rs_tag),
    .rt_tag        (rt_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .pending_count (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int rsp;
    int rst;
    int rtp;
    int rtt;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: which registers wait, and on which tag.
  bit mp[32];
  int mt[32];

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mp[i]) c++;
    return c;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mp[i] = 1'b0;
      mt[i] = 0;
    end
  endfunction

  function automatic void look(input int a, input bit cv, input int ct,
                               output int p, output int t);
    p = (a != 0 && mp[a] && !(cv && ct == mt[a])) ? 1 : 0;
    t = p ? mt[a] : 0;
  endfunction

  task automatic step(input bit fl, input bit we, input int rd,
                      input int tg, input bit cv, input int ct,
                      input int ra, input int rb);
    exp_t e;
    @(posedge clock);
    #1;
    flush      = fl;
    disp_wr_en = we;
    disp_rd    = 5'(rd);
    disp_tag   = 5'(tg);
    cdb_valid  = cv;
    cdb_tag    = 5'(ct);
    rs_addr    = 5'(ra);
    rt_addr    = 5'(rb);
    look(ra, cv, ct, e.rsp, e.rst);
    look(rb, cv, ct, e.rtp, e.rtt);
    e.cnt = model_count();
    q.push_back(e);
    if (fl) begin
      for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (cv && mp[i] && mt[i] == ct && !(we && rd == i)) mp[i] = 1'b0;
      if (we && rd != 0) begin
        mp[rd] = 1'b1;
        mt[rd] = tg;
      end
    end
  endtask

  task automatic idle(input int ra, input int rb);
    step(0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs_pending", int'(rs_pending), e.rsp);
      chk("rs_tag", int'(rs_tag), e.rst);
      chk("rt_pending", int'(rt_pending), e.rtp);
      chk("rt_tag", int'(rt_tag), e.rtt);
      chk("pending_count", int'(pending_count), e.cnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int free_q[$];
  int infl[$];

  initial begin
    model_clear();
    reset = 1'b1;
    flush = 0; disp_wr_en = 0; disp_rd = 0; disp_tag = 0;
    cdb_valid = 0; cdb_tag = 0; rs_addr = 5; rt_addr = 0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_count", int'(pending_count), 0);
    chk("reset_rs_pending", int'(rs_pending), 0);
    reset = 1'b0;

    idle(5, 0);
    at_neg();
    chk("r5_idle_pending", int'(rs_pending), 0);
    chk("r5_idle_tag", int'(rs_tag), 0);

    step(0, 1, 5, 3, 0, 0, 5, 0);
    idle(5, 0);
    at_neg();
    chk("r5_disp_pending", int'(rs_pending), 1);
    chk("r5_disp_tag", int'(rs_tag), 3);
    chk("r5_disp_count", int'(pending_count), 1);
    step(0, 0, 0, 0, 1, 3, 5, 0);
    at_neg();
    chk("r5_bypass_pending", int'(rs_pending), 0);
    chk("r5_bypass_count", int'(pending_count), 1);
    idle(5, 0);
    at_neg();
    chk("r5_cleared_count", int'(pending_count), 0);

    step(0, 1, 7, 4, 0, 0, 7, 0);
    step(0, 1, 7, 9, 0, 0, 7, 0);
    step(0, 0, 0, 0, 1, 4, 7, 0);
    at_neg();
    chk("waw_pending", int'(rs_pending), 1);
    chk("waw_tag", int'(rs_tag), 9);
    chk("waw_count", int'(pending_count), 1);
    step(0, 0, 0, 0, 1, 9, 0, 7);
    at_neg();
    chk("waw_clr_bypass", int'(rt_pending), 0);
    idle(7, 0);
    at_neg();
    chk("waw_clr_count", int'(pending_count), 0);

    step(0, 1, 2, 1, 0, 0, 2, 0);
    step(0, 1, 2, 6, 1, 1, 2, 0);
    step(0, 1, 2, 12, 0, 0, 2, 2);
    at_neg();
    chk("same_cyc_old_map", int'(rs_tag), 6);
    chk("same_cyc_count", int'(pending_count), 1);
    idle(2, 0);
    at_neg();
    chk("rename_tag", int'(rs_tag), 12);
    step(0, 0, 0, 0, 1, 12, 0, 0);

    step(0, 1, 0, 8, 0, 0, 0, 0);
    idle(0, 0);
    at_neg();
    chk("r0_pending", int'(rs_pending), 0);
    chk("r0_count", int'(pending_count), 0);

    for (int i = 1; i < 32; i++) step(0, 1, i, i, 0, 0, i, 0);
    idle(31, 1);
    at_neg();
    chk("full_count", int'(pending_count), 31);
    step(1, 1, 3, 20, 1, 5, 3, 4);
    at_neg();
    chk("flush_cyc_pre_state", int'(rs_tag), 3);
    idle(3, 0);
    at_neg();
    chk("flush_count", int'(pending_count), 0);
    chk("flush_r3", int'(rs_pending), 0);

    for (int i = 1; i <= 10; i++) step(0, 1, i, i + 10, 0, 0, 0, 0);
    idle(4, 10);
    at_neg();
    chk("pre_reset_count", int'(pending_count), 10);
    reset = 1'b1;
    disp_wr_en = 0; cdb_valid = 1; cdb_tag = 14; flush = 0;
    #1;
    chk("async_rs_pending", int'(rs_pending), 0);
    chk("async_rt_tag", int'(rt_tag), 0);
    chk("async_count", int'(pending_count), 0);
    model_clear();
    cdb_valid = 0;
    #1;
    reset = 1'b0;
    step(0, 1, 5, 2, 0, 0, 0, 0);
    idle(5, 0);
    at_neg();
    chk("post_reset_tag", int'(rs_tag), 2);
    chk("post_reset_count", int'(pending_count), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) free_q.push_back(i);
    for (int n = 0; n < 3000; n++) begin
      bit fl, we, cv, from_infl;
      int rd, tg, ct, idx;
      fl = ($urandom_range(0, 49) == 0);
      cv = 0; from_infl = 0; ct = $urandom_range(0, 31);
      we = 0; rd = 0; tg = 0;
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, infl.size() - 1);
        ct = infl[idx];
        infl.delete(idx);
        cv = 1;
        from_infl = 1;
      end else if ($urandom_range(0, 7) == 0) begin
        cv = 1;
      end
      if (free_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        tg = free_q.pop_front();
        rd = $urandom_range(0, 31);
        we = 1;
        infl.push_back(tg);
      end
      step(fl, we, rd, tg, cv, ct,
           $urandom_range(0, 31), $urandom_range(0, 31));
      if (from_infl) free_q.push_back(ct);
      if (fl) begin
        while (infl.size() > 0) free_q.push_back(infl.pop_front());
      end
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clock);
    at_neg();
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Register status table for the Tomasulo-style MIPS core. Sits directly downstream of the tag FIFO: at dispatch it records the tag handed out by the tag FIFO against the instruction's destination register. It tells dispatch, per source operand, whether the register is still waiting on an in-flight tag. Entries are cleared when the CDB broadcasts the matching tag.

## Interface
- NREG, 32, number of architectural registers; r0 is hard-wired ready.
- AREG_W, 5, architectural register index width.
- TAG_W, 5, tag width; must match the tag FIFO data width.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all pending entries (branch mispredict recovery).
- disp_wr_en  in  1  dispatch is issuing an instruction with a destination register this cycle.
- disp_rd  in  AREG_W  destination register of the dispatching instruction.
- disp_tag  in  TAG_W  tag assigned by the tag FIFO.
- rs_addr, rt_addr  in  AREG_W  source registers being looked up.
- rs_pending, rt_pending  out  1  source is waiting on a tag.
- rs_tag, rt_tag  out  TAG_W  tag being waited on; 0 when not pending.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- pending_count  out  AREG_W+1  number of pending entries.

## Operation
- State per entry: pending bit, tag. Reset: all pending=0, tags=0, pending_count=0. All outputs are therefore 0 after reset.
- Update priority per clock: flush, then dispatch write, then CDB clear.
- Flush: all pending=0 and pending_count=0. Dispatch write and CDB are ignored that cycle.
- Dispatch write (disp_wr_en, disp_rd≠0):
  - entry[disp_rd] becomes pending=1 with tag=disp_tag.
  - If the entry was already pending (WAW), the tag is overwritten and the count is unchanged.
  - Writes to r0 are dropped.
- CDB clear: every pending entry whose tag equals cdb_tag gets pending=0. An entry being written by dispatch in the same cycle is not cleared; the new tag wins.
- Tags are unique in flight, so at most one entry matches. More than one match is a protocol error, flagged by a simulation assertion.
- pending_count next value is current count, plus 1 for a write to a non-pending entry, minus 1 for a CDB clear that takes effect. It saturates at neither end; overflow is impossible by construction.
- Lookups (combinational):
  - xx_pending = entry.pending AND NOT (cdb_valid AND cdb_tag==entry.tag). This bypasses a same-cycle broadcast.
  - xx_tag = entry.tag when xx_pending, else 0.
  - r0 always returns pending=0, tag=0.
- Lookups do NOT see a same-cycle dispatch write. Sources are read before the destination is renamed, so add r1,r1,r2 reads the old mapping of r1.
- disp_tag has no internal checks; the dispatch unit only asserts disp_wr_en when the tag FIFO is non-empty.

## Timing
- Lookup: zero latency, combinational from rs_addr/rt_addr, the table, and the CDB inputs.
- Dispatch write is visible on lookups the cycle after disp_wr_en.
- CDB clear is visible immediately through the bypass, and in the table the next cycle.
- pending_count is registered and updates one cycle after the event.
- Reset asserted mid-operation clears the table immediately (async); a CDB in flight is lost. The tag FIFO resets concurrently, so this is consistent.
- Flush takes effect at the clock edge; lookups in the flush cycle still reflect the pre-flush state.

## Structure
- The shared core package holds:
  - AREG_W and TAG_W constants, shared with the tag FIFO and dispatch.
  - An rst_entry_t typedef {pending, tag}.
- One sub-module: rst_lookup, the combinational read-plus-CDB-bypass. It is instantiated twice, for rs and rt.
- Table storage is flops, not RAM, because of the parallel CDB compare.

## Test plan
- Reset, then look up r5 -> pending=0, tag=0, pending_count=0.
- Dispatch r5/tag 3, next cycle look up r5 -> pending=1, tag=3, count=1. cdb_tag=3 -> same-cycle lookup pending=0; next cycle entry cleared, count=0.
- WAW: r7 gets tag 4, then r7 gets tag 9; CDB tag 4 -> r7 stays pending with tag 9, count=1. CDB tag 9 -> cleared.
- Same cycle: dispatch r2/tag 6 and CDB tag 1 (r2 previously tag 1) -> r2 pending with tag 6, count unchanged. Same cycle: rs_addr=2 with dispatch r2 -> returns the old mapping.
- Dispatch r0/tag 8 -> r0 not pending, count unchanged. Fill r1..r31 -> count=31. Flush with a simultaneous dispatch -> all clear, count=0.
- Assert async reset between clock edges with 10 entries pending -> all outputs 0 immediately. Next dispatch works normally.
